// File: rtl/bitty_ctrl_pkg.sv
// Shared encodings for the bitty control FSM: state codes, instruction
// format and branch-condition codes, and the bus-mux select values.
package bitty_ctrl_pkg;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEM_WAIT  = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_BRANCH    = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_M = 2'b11;

  localparam logic [1:0] COND_EQ     = 2'b00;
  localparam logic [1:0] COND_GT     = 2'b01;
  localparam logic [1:0] COND_LT     = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b11;

  localparam logic [3:0] MUX_IMM = 4'b1000;

  function automatic logic [3:0] reg_mux(input logic [2:0] r);
    return {1'b0, r};
  endfunction

  // flags are ordered {eq, gt, lt}
  function automatic logic cond_holds(input logic [1:0] cond, input logic [2:0] flags);
    logic hit;
    case (cond)
      COND_EQ: hit = flags[2];
      COND_GT: hit = flags[1];
      COND_LT: hit = flags[0];
      default: hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Saturating memory-wait counter; expired is raised once the count equals
// TIMEOUT (never raised when TIMEOUT is 0).
module ctrl_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == CW'(TIMEOUT));

endmodule

// File: rtl/bitty_ctrl_fsm.sv
// Multicycle control FSM for the bitty core: decodes the registered
// instruction word into datapath enables, mux selects, ALU opcode and PC control.
module bitty_ctrl_fsm
  import bitty_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 12,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [15:0]       d_in,
  input  logic [2:0]        flags,
  input  logic              mem_ack,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              en_i,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              en_s,
  output logic              en_c,
  output logic [7:0]        en_reg,
  output logic [2:0]        alu_sel,
  output logic [3:0]        mux_sel,
  output logic [DATA_W-1:0] imm_val,
  output logic              mem_req,
  output logic              mem_we
);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [1:0]        fmt;
  logic [2:0]        ra;
  logic [2:0]        rb;
  logic [2:0]        alu;
  logic [7:0]        imm8;
  logic [1:0]        cond;
  logic [11:0]       tgt;
  logic              is_store;
  logic [DATA_W-1:0] imm_sext;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;

  assign fmt      = d_in[1:0];
  assign ra       = d_in[15:13];
  assign rb       = d_in[12:10];
  assign alu      = d_in[4:2];
  assign imm8     = d_in[12:5];
  assign cond     = d_in[3:2];
  assign tgt      = d_in[15:4];
  assign is_store = (fmt == FMT_M) && d_in[2];
  assign imm_sext = {{(DATA_W-8){imm8[7]}}, imm8};

  assign timer_enable = (state == ST_MEM_WAIT) && !mem_ack;
  assign timer_clear  = (state != ST_MEM_WAIT) || mem_ack;

  ctrl_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // err is the only registered output and stays set until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FETCH;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == ST_ERROR) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = !((state == ST_FETCH) && !run) && (state != ST_ERROR);

  always_comb begin
    state_next = state;
    done       = 1'b0;
    en_i       = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_target  = '0;
    en_s       = 1'b0;
    en_c       = 1'b0;
    en_reg     = 8'b0;
    alu_sel    = 3'b0;
    mux_sel    = 4'b0;
    imm_val    = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;

    case (state)
      ST_FETCH: begin
        if (run) begin
          en_i       = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        en_s       = 1'b1;
        mux_sel    = (fmt == FMT_M) ? reg_mux(rb) : reg_mux(ra);
        state_next = (fmt == FMT_B) ? ST_BRANCH : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        case (fmt)
          FMT_R: begin
            mux_sel    = reg_mux(rb);
            en_c       = 1'b1;
            alu_sel    = alu;
            state_next = ST_WRITEBACK;
          end
          FMT_I: begin
            mux_sel    = MUX_IMM;
            imm_val    = imm_sext;
            en_c       = 1'b1;
            alu_sel    = alu;
            state_next = ST_WRITEBACK;
          end
          FMT_M: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (is_store) begin
              mux_sel = reg_mux(ra);
            end
            if (mem_ack) begin
              en_c       = !is_store;
              state_next = ST_WRITEBACK;
            end else begin
              state_next = ST_MEM_WAIT;
            end
          end
          default: state_next = ST_FETCH;
        endcase
      end

      // Ack wins over expiry when both land on the same cycle
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (is_store) begin
          mux_sel = reg_mux(ra);
        end
        if (mem_ack) begin
          en_c       = !is_store;
          state_next = ST_WRITEBACK;
        end else if (timer_expired) begin
          state_next = ST_ERROR;
        end
      end

      ST_WRITEBACK: begin
        if (!is_store) begin
          en_reg = 8'b1 << ra;
        end
        done       = 1'b1;
        state_next = ST_FETCH;
      end

      ST_BRANCH: begin
        pc_target  = PC_W'(tgt);
        pc_load    = cond_holds(cond, flags);
        done       = 1'b1;
        state_next = ST_FETCH;
      end

      ST_ERROR: state_next = ST_ERROR;

      default: state_next = ST_FETCH;
    endcase
  end

endmodule
